// File: rtl/inst_sram_axi_rd_bridge.sv
// ---------------------------------------------------------------------------
// inst_sram_axi_rd_bridge
//
// Purpose:
//   Turns instruction-fetch requests on an SRAM-like interface into
//   single-beat AXI4 read transactions. R beats come back in request order
//   and are passed straight through as inst_sram_data_ok/inst_sram_rdata.
//   Up to MAX_OUTSTANDING requests may be accepted but not yet returned.
//
// Handshake semantics (applies to every valid/ready pair in this block):
//   A transfer happens in exactly the cycle where valid and ready are both
//   high at the rising clock edge. Once arvalid is raised, araddr/arsize and
//   the other AR fields are held stable until that transfer. On the fetch
//   side, inst_sram_en acts as valid and inst_sram_addr_ok as ready. The
//   requester may drop or change the request in any cycle without addr_ok.
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   inst_sram_*           fetch-side request/response (wen/wdata ignored)
//   ar*                   AXI read-address channel (single beat, INCR)
//   r*                    AXI read-data channel (rid/rlast ignored)
//   err_flags             sticky: [0] write request, [1] rresp error,
//                         [2] R beat with nothing outstanding
//   dbg_state_o           AR state machine state (0 idle, 1 busy)
//   dbg_cnt_o             outstanding request count
// ---------------------------------------------------------------------------
module inst_sram_axi_rd_bridge #(
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [3:0]  AXI_ID          = 4'd0,
  localparam int         CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  // fetch-side SRAM-like interface
  input  logic             inst_sram_en,
  input  logic             inst_sram_wr,
  input  logic [1:0]       inst_sram_size,
  input  logic [3:0]       inst_sram_wen,
  input  logic [31:0]      inst_sram_addr,
  input  logic [31:0]      inst_sram_wdata,
  output logic             inst_sram_addr_ok,
  output logic             inst_sram_data_ok,
  output logic [31:0]      inst_sram_rdata,
  // AXI AR channel
  output logic [3:0]       arid,
  output logic [31:0]      araddr,
  output logic [7:0]       arlen,
  output logic [2:0]       arsize,
  output logic [1:0]       arburst,
  output logic [1:0]       arlock,
  output logic [3:0]       arcache,
  output logic [2:0]       arprot,
  output logic             arvalid,
  input  logic             arready,
  // AXI R channel
  input  logic [3:0]       rid,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic             rlast,
  input  logic             rvalid,
  output logic             rready,
  // status / debug
  output logic [2:0]       err_flags,
  output logic             dbg_state_o,
  output logic [CNT_W-1:0] dbg_cnt_o
);

  localparam logic AR_IDLE = 1'b0;
  localparam logic AR_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [2:0]       arsize_q, arsize_d;
  logic [2:0]       err_q, err_d;

  logic addr_ok;
  logic data_ok;

  // Inputs that carry no meaning for a read-only fetch bridge.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wen, inst_sram_wdata, rid, rlast};

  // Accept only from registered state: no path from arready into addr_ok.
  // Gated by resetn so nothing is accepted while reset is held.
  assign addr_ok = resetn & inst_sram_en & ~inst_sram_wr &
                   (state_q == AR_IDLE) & (cnt_q < CNT_MAX);

  // In-order responses with a single ARID: any beat while something is
  // outstanding belongs to the oldest request.
  assign rready  = (cnt_q != '0);
  assign data_ok = rvalid & rready;

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arsize_d = arsize_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    case (state_q)
      AR_IDLE: begin
        if (addr_ok) begin
          araddr_d = inst_sram_addr;
          arsize_d = {1'b0, inst_sram_size};
          state_d  = AR_BUSY;
        end
      end
      AR_BUSY: begin
        if (arready) begin
          state_d = AR_IDLE;
        end
      end
      default: state_d = AR_IDLE;
    endcase

    // Simultaneous accept and return leave the count unchanged.
    case ({addr_ok, data_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (inst_sram_en & inst_sram_wr) err_d[0] = 1'b1;
    if (data_ok & (rresp != 2'b00))  err_d[1] = 1'b1;
    if (rvalid & (cnt_q == '0))      err_d[2] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= AR_IDLE;
      cnt_q    <= '0;
      araddr_q <= '0;
      arsize_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      araddr_q <= araddr_d;
      arsize_q <= arsize_d;
      err_q    <= err_d;
    end
  end

  assign inst_sram_addr_ok = addr_ok;
  assign inst_sram_data_ok = data_ok;
  assign inst_sram_rdata   = rdata;

  assign arid    = AXI_ID;
  assign araddr  = araddr_q;
  assign arlen   = 8'd0;
  assign arsize  = arsize_q;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (state_q == AR_BUSY);

  assign err_flags   = err_q;
  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// ---------------------------------------------------------------------------
// tb_inst_sram_axi_rd_bridge
//
// Directed bench for inst_sram_axi_rd_bridge (MAX_OUTSTANDING = 2).
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// one more unit later, well away from the next rising edge.
// ---------------------------------------------------------------------------
module tb_inst_sram_axi_rd_bridge;

  // ---- clock / reset --------------------------------------------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // ---- DUT signals ----------------------------------------------------
  logic        en, wr;
  logic [1:0]  size;
  logic [3:0]  wen;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [2:0]  err_flags;
  logic        dbg_state;
  logic [1:0]  dbg_cnt;

  inst_sram_axi_rd_bridge #(
    .MAX_OUTSTANDING(2),
    .AXI_ID         (4'd0)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_en      (en),
    .inst_sram_wr      (wr),
    .inst_sram_size    (size),
    .inst_sram_wen     (wen),
    .inst_sram_addr    (addr),
    .inst_sram_wdata   (wdata),
    .inst_sram_addr_ok (addr_ok),
    .inst_sram_data_ok (data_ok),
    .inst_sram_rdata   (sram_rdata),
    .arid              (arid),
    .araddr            (araddr),
    .arlen             (arlen),
    .arsize            (arsize),
    .arburst           (arburst),
    .arlock            (arlock),
    .arcache           (arcache),
    .arprot            (arprot),
    .arvalid           (arvalid),
    .arready           (arready),
    .rid               (rid),
    .rdata             (rdata),
    .rresp             (rresp),
    .rlast             (rlast),
    .rvalid            (rvalid),
    .rready            (rready),
    .err_flags         (err_flags),
    .dbg_state_o       (dbg_state),
    .dbg_cnt_o         (dbg_cnt)
  );

  // ---- scoreboard counters / data-return queue ------------------------
  int n_compared   = 0;
  int n_mismatched = 0;
  int n_data_ok    = 0;
  logic [31:0] exp_q[$];

  // ---- driver tasks ---------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present an R beat this cycle; the value must be the oldest queued one.
  task automatic drive_beat(input logic [1:0] resp);
    rvalid = 1'b1;
    rresp  = resp;
    rdata  = (exp_q.size() != 0) ? exp_q[0] : 32'hdead_beef;
  endtask

  task automatic check_beat(input string tag);
    logic [31:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
    chk({tag, "_data_ok"}, {31'd0, data_ok}, 32'd1);
    chk({tag, "_rdata"}, sram_rdata, e);
    if (data_ok) n_data_ok++;
  endtask

  // ---- directed stimulus ----------------------------------------------
  initial begin
    resetn = 1'b0; en = 1'b1; wr = 1'b0; size = 2'b10; wen = 4'h0;
    addr = 32'h0000_0040; wdata = 32'h0; arready = 1'b0;
    rid = 4'd0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;

    // Reset for 2 cycles, with a request pending to prove it is ignored.
    tick(); tick();
    settle();
    chk("rst_addr_ok", {31'd0, addr_ok}, 32'd0);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_araddr",  araddr, 32'd0);
    chk("rst_arsize",  {29'd0, arsize}, 32'd0);
    chk("rst_rready",  {31'd0, rready}, 32'd0);
    chk("rst_err",     {29'd0, err_flags}, 32'd0);
    chk("rst_cnt",     {30'd0, dbg_cnt}, 32'd0);

    // ---- single fetch ----
    tick();
    resetn = 1'b1; en = 1'b0;
    tick();                                   // cycle T
    en = 1'b1; addr = 32'hbfc0_0000; settle();
    chk("sf_addr_ok", {31'd0, addr_ok}, 32'd1);
    exp_q.push_back(32'h3c1a_bfc0);
    tick();                                   // T+1
    en = 1'b0; arready = 1'b1; settle();
    chk("sf_arvalid", {31'd0, arvalid}, 32'd1);
    chk("sf_araddr",  araddr, 32'hbfc0_0000);
    chk("sf_arsize",  {29'd0, arsize}, 32'd2);
    chk("sf_arlen",   {24'd0, arlen}, 32'd0);
    chk("sf_arconst", {arid, arburst, arlock, arcache, arprot}, {4'd0, 2'b01, 2'b00, 4'd0, 3'd0});
    chk("sf_rready",  {31'd0, rready}, 32'd1);
    tick();                                   // T+2
    arready = 1'b0; settle();
    chk("sf_arvalid_drop", {31'd0, arvalid}, 32'd0);
    tick();                                   // T+3
    drive_beat(2'b00); settle();
    check_beat("sf");
    tick();
    rvalid = 1'b0; settle();
    chk("sf_cnt",    {30'd0, dbg_cnt}, 32'd0);
    chk("sf_rready0", {31'd0, rready}, 32'd0);

    // ---- AR backpressure ----
    en = 1'b1; addr = 32'h0000_1000; settle();
    chk("bp_addr_ok", {31'd0, addr_ok}, 32'd1);
    exp_q.push_back(32'h1111_2222);
    tick();
    addr = 32'h0000_2000;
    for (int i = 0; i < 6; i++) begin
      arready = (i == 5); settle();
      chk("bp_arvalid", {31'd0, arvalid}, 32'd1);
      chk("bp_araddr",  araddr, 32'h0000_1000);
      chk("bp_addr_ok_stall", {31'd0, addr_ok}, 32'd0);
      tick();
    end
    en = 1'b0; arready = 1'b0; settle();
    chk("bp_arvalid_drop", {31'd0, arvalid}, 32'd0);
    tick();
    drive_beat(2'b00); settle();
    check_beat("bp");
    tick();
    rvalid = 1'b0; settle();
    chk("bp_cnt", {30'd0, dbg_cnt}, 32'd0);

    // ---- outstanding limit ----
    n_data_ok = 0;
    arready = 1'b1;
    en = 1'b1; addr = 32'hbfc0_0100; settle();
    chk("ol_addr_ok0", {31'd0, addr_ok}, 32'd1);
    exp_q.push_back(32'ha000_0000);
    tick();
    addr = 32'hbfc0_0104; settle();
    chk("ol_busy_block", {31'd0, addr_ok}, 32'd0);
    tick(); settle();
    chk("ol_addr_ok1", {31'd0, addr_ok}, 32'd1);
    exp_q.push_back(32'ha000_0004);
    tick();
    addr = 32'hbfc0_0108; settle();
    chk("ol_araddr1", araddr, 32'hbfc0_0104);
    tick();
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("ol_cnt_max", {30'd0, dbg_cnt}, 32'd2);
      chk("ol_limit_block", {31'd0, addr_ok}, 32'd0);
      tick();
    end
    drive_beat(2'b00); settle();
    chk("ol_no_lookahead", {31'd0, addr_ok}, 32'd0);
    check_beat("ol0");
    tick();
    rvalid = 1'b0; settle();
    chk("ol_cnt_dec", {30'd0, dbg_cnt}, 32'd1);
    chk("ol_addr_ok2", {31'd0, addr_ok}, 32'd1);
    exp_q.push_back(32'ha000_0008);
    tick();
    en = 1'b0; settle();
    chk("ol_araddr2", araddr, 32'hbfc0_0108);
    chk("ol_cnt_2",   {30'd0, dbg_cnt}, 32'd2);
    tick();
    drive_beat(2'b00); settle(); check_beat("ol1"); tick();
    drive_beat(2'b00); settle(); check_beat("ol2"); tick();
    rvalid = 1'b0; settle();
    chk("ol_cnt_end", {30'd0, dbg_cnt}, 32'd0);
    chk("ol_data_ok_count", n_data_ok, 32'd3);

    // ---- simultaneous addr_ok and data_ok ----
    en = 1'b1; addr = 32'h0000_0200; settle();
    chk("sim_addr_ok0", {31'd0, addr_ok}, 32'd1);
    exp_q.push_back(32'h5555_0200);
    tick();
    en = 1'b0; tick();
    en = 1'b1; addr = 32'h0000_0204;
    drive_beat(2'b00); settle();
    chk("sim_addr_ok", {31'd0, addr_ok}, 32'd1);
    check_beat("sim");
    exp_q.push_back(32'h5555_0204);
    tick();
    en = 1'b0; rvalid = 1'b0; settle();
    chk("sim_cnt_same", {30'd0, dbg_cnt}, 32'd1);
    chk("sim_araddr",   araddr, 32'h0000_0204);
    tick();

    // ---- rresp error: data still returned ----
    drive_beat(2'b10); settle();
    chk("rresp_err_before", {29'd0, err_flags}, 32'd0);
    check_beat("rresp");
    tick();
    rvalid = 1'b0; rresp = 2'b00; settle();
    chk("rresp_err_flag", {29'd0, err_flags}, 32'b010);
    chk("rresp_cnt",      {30'd0, dbg_cnt}, 32'd0);

    // ---- R beat with nothing outstanding ----
    rvalid = 1'b1; rdata = 32'h0bad_0bad; settle();
    chk("spur_rready",  {31'd0, rready}, 32'd0);
    chk("spur_data_ok", {31'd0, data_ok}, 32'd0);
    tick();
    rvalid = 1'b0; settle();
    chk("spur_err_flag", {29'd0, err_flags}, 32'b110);
    chk("spur_cnt",      {30'd0, dbg_cnt}, 32'd0);

    // ---- write request ----
    en = 1'b1; wr = 1'b1; addr = 32'h0000_0300; settle();
    chk("wr_addr_ok", {31'd0, addr_ok}, 32'd0);
    tick();
    en = 1'b0; wr = 1'b0; settle();
    chk("wr_err_flag", {29'd0, err_flags}, 32'b111);
    chk("wr_arvalid",  {31'd0, arvalid}, 32'd0);

    // ---- reset mid-flight ----
    arready = 1'b0;
    en = 1'b1; addr = 32'h0000_0400; settle();
    chk("mr_addr_ok", {31'd0, addr_ok}, 32'd1);
    tick();
    en = 1'b0; settle();
    chk("mr_arvalid_pre", {31'd0, arvalid}, 32'd1);
    chk("mr_cnt_pre",     {30'd0, dbg_cnt}, 32'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1; settle();
    chk("mr_arvalid", {31'd0, arvalid}, 32'd0);
    chk("mr_rready",  {31'd0, rready}, 32'd0);
    chk("mr_err",     {29'd0, err_flags}, 32'd0);
    chk("mr_cnt",     {30'd0, dbg_cnt}, 32'd0);
    chk("mr_state",   {31'd0, dbg_state}, 32'd0);

    // ---- final report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/inst_sram_axi_rd_bridge.md
# inst_sram_axi_rd_bridge

Responder end of the instruction-side SRAM-like interface that the fetch stage drives. It accepts fetch read requests (`inst_sram_en`/`inst_sram_addr`, answered with `inst_sram_addr_ok`), issues them as single-beat AXI4 read transactions, and returns each AXI R beat as `inst_sram_data_ok`/`inst_sram_rdata` in request order. It sits between the fetch stage and the top-level AXI read arbiter, and supports up to `MAX_OUTSTANDING` requests in flight.

## Interface
- `MAX_OUTSTANDING`, 2: maximum accepted-but-unreturned requests; legal range 1..3.
- `AXI_ID`, 4'd0: constant ARID driven on every transaction.
- `clk`  in  1  the single clock; every register updates on its rising edge.
- `resetn`  in  1  reset, synchronous and active-low.
- `inst_sram_en`  in  1  request valid.
- `inst_sram_wr`  in  1  write flag; 1 is unsupported.
- `inst_sram_size`  in  2  log2 of bytes; always 2'b10 for fetch.
- `inst_sram_wen`  in  4  ignored.
- `inst_sram_addr`  in  32  request byte address.
- `inst_sram_wdata`  in  32  ignored.
- `inst_sram_addr_ok`  out  1  request accepted this cycle.
- `inst_sram_data_ok`  out  1  read data valid this cycle.
- `inst_sram_rdata`  out  32  read data.
- `arid`  out 4, `araddr`  out 32, `arlen`  out 8, `arsize`  out 3, `arburst`  out 2, `arlock`  out 2, `arcache`  out 4, `arprot`  out 3, `arvalid`  out 1, `arready`  in 1: AXI AR channel.
- `rid`  in 4, `rdata`  in 32, `rresp`  in 2, `rlast`  in 1, `rvalid`  in 1, `rready`  out 1: AXI R channel.
- `err_flags`  out  3  sticky error bits: [0] write request seen, [1] `rresp` non-OKAY, [2] R beat arrived with nothing outstanding.

## Operation
- **AR state machine**
  - States: AR_IDLE and AR_BUSY.
  - `addr_ok = inst_sram_en & ~inst_sram_wr & (state==AR_IDLE) & (cnt < MAX_OUTSTANDING)`. This is combinational from registered state only; there is no combinational path from `arready`.
  - When `addr_ok` is high: latch `araddr <= inst_sram_addr` and `arsize <= {1'b0, inst_sram_size}`, then go to AR_BUSY.
  - In AR_BUSY: `arvalid = 1` and the latched AR fields are held stable. On `arvalid & arready`, go back to AR_IDLE.
- **AR constant fields:** `arid = AXI_ID`, `arlen = 0`, `arburst = 2'b01`, `arlock = 0`, `arcache = 0`, `arprot = 0`.
- **Outstanding counter `cnt`**
  - Width is `$clog2(MAX_OUTSTANDING+1)`.
  - `+1` on `addr_ok`; `-1` on `data_ok`. When both happen in the same cycle, `cnt` is unchanged.
  - `cnt` never wraps: `addr_ok` is blocked at the maximum, and no decrement occurs at 0.
- **R channel**
  - `rready = (cnt != 0)`.
  - `data_ok = rvalid & rready`, and `inst_sram_rdata = rdata`. Both are combinational pass-through, so data is valid in the beat's handshake cycle.
  - `rid` and `rlast` are ignored; responses are in order because ARID is a single constant.
- **Error flags**
  - `err_flags[0]` is set when `inst_sram_en & inst_sram_wr`. That request is never accepted (`addr_ok = 0`), so the requester stalls. This is a debug aid only.
  - `err_flags[1]` is set on `data_ok & (rresp != 0)`. The data is still returned.
  - `err_flags[2]` is set on `rvalid & (cnt == 0)`. The beat is not consumed.
- **Cancellation:** the bridge has no cancel or flush input. The requester discards data belonging to cancelled requests; the bridge always returns exactly one `data_ok` per `addr_ok`.

## Timing
- **Reset values** (`resetn = 0` at a clock edge):
  - state AR_IDLE, `cnt = 0`, `arvalid = 0`, `araddr = 0`, `arsize = 0`, `err_flags = 0`.
  - As a consequence, `rready = 0`, `addr_ok = 0` (while reset is held), and `data_ok = 0`.
- **Reset mid-operation:** in-flight AR and R state is dropped without completion. The system resets the AXI slave in the same cycle.
- **Minimum latency**
  - `addr_ok` occurs in cycle T.
  - `arvalid` is high from T+1.
  - With `arready` high at T+1, the earliest `rvalid`/`data_ok` is T+2.
  - The earliest next `addr_ok` is T+2: one AR in flight at a time, so the maximum AR issue rate is one request per 2 cycles.
- **Stalls**
  - While `arready` is low, `arvalid` and the AR fields hold, and `addr_ok` stays 0.
  - `addr_ok` stays 0 while `cnt == MAX_OUTSTANDING`, even if AR is idle. It may reassert in the same cycle that a `data_ok` brings `cnt` below the maximum only if `cnt` was already below the maximum at the start of that cycle; `cnt` is registered, so no look-ahead.
- **Requester contract:** the requester may drop or change `inst_sram_en`/`inst_sram_addr` in any cycle without `addr_ok`. The bridge latches only on `addr_ok`.

## Test plan
- **Single fetch:** reset for 2 cycles; `en = 1`, `addr = 0xbfc00000`.
  - Expect `addr_ok` at T, then `araddr = 0xbfc00000`, `arsize = 3'b010`, `arlen = 0`, `arvalid` at T+1.
  - Slave `arready` at T+1, `rvalid` with `rdata = 0x3c1abfc0` at T+3 → `data_ok = 1`, `rdata = 0x3c1abfc0` at T+3, `cnt` back to 0.
- **AR backpressure:** `arready` held low for 5 cycles → `arvalid` and `araddr` are stable for 6 cycles, and `addr_ok = 0` throughout despite `en = 1`.
- **Outstanding limit** (`MAX_OUTSTANDING = 2`): issue 0x…00, 0x…04, 0x…08 with R withheld.
  - Expect only 2 `addr_ok`s; the third waits.
  - Return one R beat → `cnt` 2→1, and the third `addr_ok` follows.
  - Return data in order → exactly three `data_ok`s.
- **Simultaneous events:** a cycle with both `addr_ok` and `data_ok` → `cnt` unchanged.
- **Errors:**
  - `rresp = 2'b10` → data is returned and `err_flags[1] = 1` from the next cycle.
  - `rvalid` with `cnt = 0` → `rready = 0` and `err_flags[2] = 1`.
  - `en = 1`, `wr = 1` → no `addr_ok`, and `err_flags[0] = 1`.
- **Reset mid-flight:** `resetn = 0` while `arvalid = 1` and `cnt = 1` → the next cycle has `arvalid = 0`, `rready = 0`, `err_flags = 0`.
